// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register, write-back select and bypassed 32x32 register file
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] EXMEM_AluRES,
  input  logic [XLEN-1:0] EXMEM_PcPlus4,
  input  logic [AW-1:0]   EXMEM_Rd,
  input  logic            EXMEM_RegWrite,
  input  logic [1:0]      EXMEM_WbSel,
  input  logic            EXMEM_Valid,
  input  logic [XLEN-1:0] EXMEM_LoadData,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [AW-1:0]   MEMWB_Rd,
  output logic            MEMWB_RegWrite,
  output logic [XLEN-1:0] MEMWB_WrData,
  output logic            MEMWB_Valid
);

  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [1:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ld_hold_q;
  logic            stall_q;
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] ld_src;
  logic [XLEN-1:0] wr_data;
  logic            wr_en;

  always_comb begin
    alu_d   = alu_q;
    pc4_d   = pc4_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      alu_d   = EXMEM_AluRES;
      pc4_d   = EXMEM_PcPlus4;
      rd_d    = EXMEM_Rd;
      rw_d    = EXMEM_RegWrite;
      sel_d   = EXMEM_WbSel;
      valid_d = EXMEM_Valid;
    end
  end

  // On the first stalled edge the memory stage still shows the held entry's load; latch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q     <= '0;
      pc4_q     <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      ld_hold_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      stall_q <= stall;
      if (stall && !stall_q) ld_hold_q <= EXMEM_LoadData;
    end
  end

  always_comb begin
    ld_src = stall_q ? ld_hold_q : EXMEM_LoadData;
    case (sel_q)
      2'b01:   wr_data = ld_src;
      2'b10:   wr_data = pc4_q;
      default: wr_data = alu_q;
    endcase
  end

  assign MEMWB_Rd       = rd_q;
  assign MEMWB_Valid    = valid_q;
  assign MEMWB_RegWrite = valid_q & rw_q & (rd_q != '0);
  assign MEMWB_WrData   = wr_data;
  assign wr_en          = MEMWB_RegWrite & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[rd_q] <= wr_data;
    end
  end

  // Write-through bypass so a read in the write cycle sees the committing value.
  always_comb begin
    if (rs1_addr == '0)                     rs1_data = '0;
    else if (wr_en && (rs1_addr == rd_q))   rs1_data = wr_data;
    else                                    rs1_data = rf_q[rs1_addr];
    if (rs2_addr == '0)                     rs2_data = '0;
    else if (wr_en && (rs2_addr == rd_q))   rs2_data = wr_data;
    else                                    rs2_data = rf_q[rs2_addr];
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] EXMEM_AluRES, EXMEM_PcPlus4, EXMEM_LoadData;
  logic [4:0]  EXMEM_Rd;
  logic        EXMEM_RegWrite, EXMEM_Valid;
  logic [1:0]  EXMEM_WbSel;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  MEMWB_Rd;
  logic        MEMWB_RegWrite, MEMWB_Valid;
  logic [31:0] MEMWB_WrData;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .EXMEM_AluRES(EXMEM_AluRES), .EXMEM_PcPlus4(EXMEM_PcPlus4),
    .EXMEM_Rd(EXMEM_Rd), .EXMEM_RegWrite(EXMEM_RegWrite),
    .EXMEM_WbSel(EXMEM_WbSel), .EXMEM_Valid(EXMEM_Valid),
    .EXMEM_LoadData(EXMEM_LoadData),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .MEMWB_Rd(MEMWB_Rd), .MEMWB_RegWrite(MEMWB_RegWrite),
    .MEMWB_WrData(MEMWB_WrData), .MEMWB_Valid(MEMWB_Valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic rw, input logic [31:0] d);
    exp_t e;
    e.rd = rd; e.rw = rw; e.data = d;
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic rw, input logic [1:0] sel);
    EXMEM_AluRES = alu; EXMEM_PcPlus4 = pc4; EXMEM_Rd = rd;
    EXMEM_RegWrite = rw; EXMEM_WbSel = sel; EXMEM_Valid = 1'b1;
  endtask

  task automatic idle;
    EXMEM_Valid = 1'b0; EXMEM_RegWrite = 1'b0;
  endtask

  // Monitor: held entries are compared every stalled cycle, popped on the committing cycle.
  always @(negedge clk) begin
    if (rst_n && MEMWB_Valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_wb: rd=%0d data=%h, expected no valid entry", MEMWB_Rd, MEMWB_WrData);
      end else begin
        mon_e = exp_q[0];
        chk("wb_rd", 32'(MEMWB_Rd), 32'(mon_e.rd));
        chk("wb_regwrite", 32'(MEMWB_RegWrite), 32'(mon_e.rw));
        chk("wb_wrdata", MEMWB_WrData, mon_e.data);
        if (!stall) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    EXMEM_AluRES = '0; EXMEM_PcPlus4 = '0; EXMEM_LoadData = '0;
    EXMEM_Rd = '0; EXMEM_RegWrite = 1'b0; EXMEM_WbSel = 2'b00; EXMEM_Valid = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    step; step;
    chk("rst_valid", 32'(MEMWB_Valid), 32'd0);
    chk("rst_wrdata", MEMWB_WrData, 32'd0);
    chk("rst_rs1", rs1_data, 32'd0);
    rst_n = 1'b1;

    drive(32'h1234, 32'h0, 5'd5, 1'b1, 2'b00);
    exp_q.push_back(mk(5'd5, 1'b1, 32'h1234));
    step; idle(); step;
    rs1_addr = 5'd5; #1;
    chk("x5_written", rs1_data, 32'h1234);

    // Reset with x6 in flight: discarded and x5 cleared
    drive(32'h77, 32'h0, 5'd6, 1'b1, 2'b00);
    step; idle();
    rst_n = 1'b0; #1;
    chk("rst_mid_x5", rs1_data, 32'd0);
    chk("rst_mid_valid", 32'(MEMWB_Valid), 32'd0);
    chk("rst_mid_wrdata", MEMWB_WrData, 32'd0);
    step; step;
    rst_n = 1'b1; rs1_addr = 5'd6; #1;
    chk("rst_x6_discarded", rs1_data, 32'd0);

    drive(32'hDEADBEEF, 32'h0, 5'd3, 1'b1, 2'b00);
    exp_q.push_back(mk(5'd3, 1'b1, 32'hDEADBEEF));
    step; idle();
    rs1_addr = 5'd3; #1;
    chk("alu_bypass", rs1_data, 32'hDEADBEEF);
    step;
    chk("alu_rf", rs1_data, 32'hDEADBEEF);

    // Load followed by a 3-cycle stall while memory data changes
    drive(32'h40, 32'h0, 5'd8, 1'b1, 2'b01);
    exp_q.push_back(mk(5'd8, 1'b1, 32'hFFFFFF80));
    step; idle();
    EXMEM_LoadData = 32'hFFFFFF80; stall = 1'b1; rs1_addr = 5'd8; #1;
    chk("ld_stall_nowrite0", rs1_data, 32'd0);
    step;
    EXMEM_LoadData = 32'h11;
    step;
    chk("ld_stall_nowrite1", rs1_data, 32'd0);
    step;
    stall = 1'b0; #1;
    chk("ld_release_bypass", rs1_data, 32'hFFFFFF80);
    step;
    chk("ld_rf", rs1_data, 32'hFFFFFF80);

    drive(32'h55, 32'h0, 5'd0, 1'b1, 2'b00);
    exp_q.push_back(mk(5'd0, 1'b0, 32'h55));
    step; idle();
    rs1_addr = 5'd0; #1;
    chk("x0_read", rs1_data, 32'd0);
    step;
    chk("x0_after", rs1_data, 32'd0);

    drive(32'h99, 32'h0, 5'd7, 1'b1, 2'b00);
    flush = 1'b1;
    step; idle(); flush = 1'b0; #1;
    chk("flush_valid", 32'(MEMWB_Valid), 32'd0);
    drive(32'h99, 32'h0, 5'd7, 1'b1, 2'b00);
    flush = 1'b1; stall = 1'b1;
    step; idle(); flush = 1'b0; stall = 1'b0; #1;
    chk("flush_stall_valid", 32'(MEMWB_Valid), 32'd0);
    step;
    rs1_addr = 5'd7; #1;
    chk("flush_x7", rs1_data, 32'd0);

    drive(32'hAAAA, 32'h104, 5'd1, 1'b1, 2'b10);
    exp_q.push_back(mk(5'd1, 1'b1, 32'h104));
    step;
    drive(32'h1, 32'h0, 5'd2, 1'b1, 2'b11);
    exp_q.push_back(mk(5'd2, 1'b1, 32'h1));
    step;
    drive(32'h2, 32'h0, 5'd2, 1'b1, 2'b00);
    exp_q.push_back(mk(5'd2, 1'b1, 32'h2));
    step; idle();
    rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    chk("x1_link", rs1_data, 32'h104);
    chk("x2_bypass", rs2_data, 32'h2);
    step;
    chk("x2_rf", rs2_data, 32'h2);

    step;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
